// File: rtl/nla_pkg.sv
// Shared fp32 constants, field widths and FSM state type for the non-linear approximation engine.
package nla_pkg;

  localparam int          FP32_EXP_W = 8;
  localparam int          FP32_MAN_W = 23;
  localparam logic [31:0] FP32_QNAN  = 32'h7FC0_0000;
  localparam logic [31:0] FP32_ONE   = 32'h3F80_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } horner_state_t;

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
  endfunction

endpackage

// File: rtl/horner_fp_mac.sv
// Fused fp32 a*b+c with a single round-to-nearest-even, followed by a MAC_LAT-deep register pipeline.
module horner_fp_mac
  import nla_pkg::*;
#(
  parameter int MAC_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic        out_valid,
  output logic [31:0] result
);

  // Exact product sits at [71:24]; 24 guard bits below keep subtraction and rounding exact.
  localparam int AW = 74;

  function automatic logic [AW-1:0] shr_sticky(input logic [AW-1:0] v, input int d);
    logic [AW-1:0] s;
    s    = v >> d;
    s[0] = s[0] | ((s << d) != v);
    return s;
  endfunction

  function automatic logic [31:0] fp32_fma(input logic [31:0] fa_in, input logic [31:0] fb_in,
                                           input logic [31:0] fc_in);
    logic                  sa, sb, sc, sp, sign_r;
    logic [FP32_EXP_W-1:0] ea, eb, ec;
    logic [FP32_MAN_W:0]   fa, fb, fc;
    logic [47:0]           prod;
    logic [AW-1:0]         p_al, c_al, r, m;
    logic [24:0]           mant_r;
    logic                  inc;
    int                    e_p, e_c, emax, n, e_res, top_pos, sh, exp_i;
    logic [31:0]           res;

    sa = fa_in[31];
    sb = fb_in[31];
    sc = fc_in[31];
    sp = sa ^ sb;
    ea = (fa_in[30:23] == 8'd0) ? 8'd1 : fa_in[30:23];
    eb = (fb_in[30:23] == 8'd0) ? 8'd1 : fb_in[30:23];
    ec = (fc_in[30:23] == 8'd0) ? 8'd1 : fc_in[30:23];
    fa = {fa_in[30:23] != 8'd0, fa_in[22:0]};
    fb = {fb_in[30:23] != 8'd0, fb_in[22:0]};
    fc = {fc_in[30:23] != 8'd0, fc_in[22:0]};
    prod = {24'd0, fa} * {24'd0, fb};

    res    = 32'd0;
    sign_r = 1'b0;
    p_al   = '0;
    c_al   = '0;
    r      = '0;
    m      = '0;
    mant_r = '0;
    inc    = 1'b0;
    n      = 0;
    e_res  = 0;
    exp_i  = 0;

    e_p = int'(ea) + int'(eb) - 127;
    e_c = int'(ec);
    if (prod == 48'd0) e_p = e_c;
    if (fc == 24'd0)   e_c = e_p;

    if (is_nan(fa_in) || is_nan(fb_in) || is_nan(fc_in)) begin
      res = FP32_QNAN;
    end else if (is_inf(fa_in) || is_inf(fb_in)) begin
      if ((fa_in[30:0] == 31'd0) || (fb_in[30:0] == 31'd0))  res = FP32_QNAN;
      else if (is_inf(fc_in) && (sc != sp))                   res = FP32_QNAN;
      else                                                    res = {sp, 8'hFF, 23'd0};
    end else if (is_inf(fc_in)) begin
      res = fc_in;
    end else if ((prod == 48'd0) && (fc == 24'd0)) begin
      res = {(sp == sc) ? sp : 1'b0, 31'd0};
    end else begin
      if (e_p >= e_c) begin
        emax = e_p;
        p_al = {2'b00, prod, 24'd0};
        c_al = shr_sticky({3'b000, fc, 47'd0}, e_p - e_c);
      end else begin
        emax = e_c;
        p_al = shr_sticky({2'b00, prod, 24'd0}, e_c - e_p);
        c_al = {3'b000, fc, 47'd0};
      end

      if (sp == sc) begin
        r      = p_al + c_al;
        sign_r = sp;
      end else if (p_al >= c_al) begin
        r      = p_al - c_al;
        sign_r = sp;
      end else begin
        r      = c_al - p_al;
        sign_r = sc;
      end

      if (r == '0) begin
        res = 32'd0;
      end else begin
        for (int i = 0; i < AW; i++) if (r[i]) n = i;
        e_res   = n + emax - 70;
        top_pos = (e_res >= 1) ? n : (71 - emax);
        sh      = 73 - top_pos;
        m       = (sh >= 0) ? (r << sh) : shr_sticky(r, -sh);
        inc     = m[49] & ((|m[48:0]) | m[50]);
        mant_r  = {1'b0, m[73:50]} + {24'd0, inc};
        if (e_res >= 1) exp_i = mant_r[24] ? e_res + 1 : e_res;
        else            exp_i = mant_r[23] ? 1 : 0;
        if (exp_i >= 255)    res = {sign_r, 8'hFF, 23'd0};
        else if (mant_r[24]) res = {sign_r, exp_i[7:0], 23'd0};
        else                 res = {sign_r, exp_i[7:0], mant_r[22:0]};
      end
    end
    return res;
  endfunction

  logic [MAC_LAT-1:0] vld_q;
  logic [31:0]        res_q [MAC_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < MAC_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // NOTE: pipeline data is qualified by vld_q, so it needs no reset and stays a plain register chain.
  always_ff @(posedge clk) begin
    res_q[0] <= fp32_fma(a, b, c);
    for (int i = 1; i < MAC_LAT; i++) res_q[i] <= res_q[i-1];
  end

  assign out_valid = vld_q[MAC_LAT-1];
  assign result    = res_q[MAC_LAT-1];

endmodule

// File: rtl/horner_poly_engine.sv
// Horner evaluator: banked coefficient RAM, per-bank series length, FSM driving one fp32 MAC op at a time.
module horner_poly_engine
  import nla_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LINES = 5,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_W     = 2,
  parameter int MAC_LAT    = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  coef_we,
  input  logic [BANK_W-1:0]     coef_bank,
  input  logic [ADDR_LINES-1:0] coef_addr,
  input  logic [DATA_WIDTH-1:0] coef_wdata,
  input  logic                  len_we,
  input  logic [ADDR_LINES-1:0] len_wdata,
  output logic                  coef_err,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [BANK_W-1:0]     in_bank,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_LINES;

  logic [DATA_WIDTH-1:0] coef_ram [NUM_BANKS*DEPTH];
  logic [ADDR_LINES-1:0] len_q    [NUM_BANKS];

  horner_state_t         state_q;
  logic [DATA_WIDTH-1:0] x_q, acc_q;
  logic [BANK_W-1:0]     bank_q;
  logic [ADDR_LINES-1:0] k_q, k_dec;
  logic [DATA_WIDTH-1:0] rd_hi, rd_lo;
  logic                  wr_block;

  logic                  mac_in_valid, mac_out_valid;
  logic [DATA_WIDTH-1:0] mac_a, mac_c, mac_res;

  assign busy      = (state_q != IDLE);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = acc_q;

  // The bank being evaluated is frozen until its result is consumed.
  assign wr_block = busy && (coef_bank == bank_q);

  assign k_dec = k_q - ADDR_LINES'(1);
  assign rd_hi = coef_ram[{bank_q, k_q}];
  assign rd_lo = coef_ram[{bank_q, k_dec}];

  always_ff @(posedge clk_i) begin
    if (coef_we && !wr_block) coef_ram[{coef_bank, coef_addr}] <= coef_wdata;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_BANKS; i++) len_q[i] <= '0;
      coef_err <= 1'b0;
    end else begin
      if (len_we && !wr_block) len_q[coef_bank] <= len_wdata;
      coef_err <= (coef_we || len_we) && wr_block;
    end
  end

  // The first op launches as SEED exits; each later op launches the cycle the previous result lands.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    mac_in_valid = 1'b0;
    mac_a        = mac_res;
    mac_c        = rd_lo;
    case (state_q)
      SEED: begin
        if (!is_nan(x_q) && (k_q != '0)) begin
          mac_in_valid = 1'b1;
          mac_a        = rd_hi;
        end
      end
      ITER:    mac_in_valid = mac_out_valid && (k_q != '0);
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      acc_q   <= '0;
      bank_q  <= '0;
      k_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q     <= in_data;
            bank_q  <= in_bank;
            k_q     <= len_q[in_bank];
            state_q <= SEED;
          end
        end
        SEED: begin
          if (is_nan(x_q)) begin
            acc_q   <= FP32_QNAN;
            state_q <= DONE;
          end else begin
            acc_q <= rd_hi;
            if (k_q == '0) begin
              state_q <= DONE;
            end else begin
              k_q     <= k_dec;
              state_q <= ITER;
            end
          end
        end
        ITER: begin
          if (mac_out_valid) begin
            acc_q <= mac_res;
            if (k_q == '0) state_q <= DONE;
            else           k_q     <= k_dec;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  horner_fp_mac #(
    .MAC_LAT (MAC_LAT)
  ) u_mac (
    .clk       (clk_i),
    .rst_n     (rstn_i),
    .in_valid  (mac_in_valid),
    .a         (mac_a),
    .b         (x_q),
    .c         (mac_c),
    .out_valid (mac_out_valid),
    .result    (mac_res)
  );

endmodule

// File: tb/tb_horner_poly_engine.sv
// Directed bench for horner_poly_engine: hand-computed fp32 results, latencies and handshake behaviour.
module tb_horner_poly_engine;
  import nla_pkg::*;

  localparam int DW = 32;
  localparam int AL = 5;
  localparam int NB = 4;
  localparam int BW = 2;
  localparam int ML = 4;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          coef_we = 1'b0;
  logic [BW-1:0] coef_bank = '0;
  logic [AL-1:0] coef_addr = '0;
  logic [DW-1:0] coef_wdata = '0;
  logic          len_we = 1'b0;
  logic [AL-1:0] len_wdata = '0;
  logic          coef_err;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [BW-1:0] in_bank = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  horner_poly_engine #(
    .DATA_WIDTH (DW),
    .ADDR_LINES (AL),
    .NUM_BANKS  (NB),
    .BANK_W     (BW),
    .MAC_LAT    (ML)
  ) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .coef_we    (coef_we),
    .coef_bank  (coef_bank),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .len_we     (len_we),
    .len_wdata  (len_wdata),
    .coef_err   (coef_err),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_bank    (in_bank),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr_coef(input logic [BW-1:0] bank, input logic [AL-1:0] addr,
                         input logic [DW-1:0] data);
    coef_we = 1'b1; coef_bank = bank; coef_addr = addr; coef_wdata = data;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic wr_len(input logic [BW-1:0] bank, input logic [AL-1:0] len);
    len_we = 1'b1; coef_bank = bank; len_wdata = len;
    tick();
    len_we = 1'b0;
  endtask

  // elapsed = cycles since the input handshake edge at the moment of the call; lat=-1 on timeout.
  task automatic wait_out(input int elapsed, output int lat);
    lat = -1;
    for (int c = elapsed; c < elapsed + 200; c++) begin
      if (out_valid) begin
        lat = c;
        break;
      end
      tick();
    end
  endtask

  task automatic pop_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic eval(input logic [DW-1:0] x, input logic [BW-1:0] bank,
                      output logic [DW-1:0] res, output int lat);
    int guard;
    guard = 0;
    res   = '0;
    while (!in_ready && guard < 200) begin
      tick();
      guard++;
    end
    in_valid = 1'b1; in_data = x; in_bank = bank;
    tick();
    in_valid = 1'b0;
    wait_out(1, lat);
    res = out_data;
    pop_out();
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    repeat (2) tick();
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 32'd0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    total++; if (coef_err !== 1'b0)  begin bad++; $display("FAIL reset_coef_err got=%b exp=0", coef_err); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rstn_i = 1'b1;
    tick();
  endtask

  task automatic test_eval_bank0();
    logic [DW-1:0] res;
    int            lat;
    logic [DW-1:0] xs  [4] = '{32'h4000_0000, 32'hBF80_0000, 32'h0000_0000, 32'h4040_0000};
    logic [DW-1:0] exp [4] = '{32'h40A0_0000, 32'h3F00_0000, FP32_ONE,      32'h4108_0000};
    wr_coef(0, 0, FP32_ONE);
    wr_coef(0, 1, 32'h3F80_0000);
    wr_coef(0, 2, 32'h3F00_0000);
    wr_len(0, 2);
    for (int i = 0; i < 4; i++) begin
      eval(xs[i], 0, res, lat);
      total++; if (res !== exp[i]) begin bad++; $display("FAIL bank0_result x=%h got=%h exp=%h", xs[i], res, exp[i]); end
      total++; if (lat !== 2 + 2 * ML) begin bad++; $display("FAIL bank0_latency x=%h got=%0d exp=%0d", xs[i], lat, 2 + 2 * ML); end
    end
  endtask

  task automatic test_len_zero();
    wr_len(1, 0);
    wr_coef(1, 0, 32'h3F00_0000);
    in_valid = 1'b1; in_data = 32'h4049_0FDB; in_bank = 1;
    tick();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL l0_seed_in_ready got=%b exp=0", in_ready); end
    total++; if (busy !== 1'b1)      begin bad++; $display("FAIL l0_seed_busy got=%b exp=1", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL l0_seed_out_valid got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1)        begin bad++; $display("FAIL l0_out_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 32'h3F00_0000) begin bad++; $display("FAIL l0_out_data got=%h exp=3f000000", out_data); end
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL l0_done_in_ready got=%b exp=0", in_ready); end
    pop_out();
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL l0_idle_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL l0_idle_out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL l0_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_nan();
    logic [DW-1:0] res;
    int            lat;
    eval(32'h7F90_0000, 0, res, lat);
    total++; if (res !== FP32_QNAN) begin bad++; $display("FAIL nan_result got=%h exp=%h", res, FP32_QNAN); end
    total++; if (lat !== 2)         begin bad++; $display("FAIL nan_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_back_to_back();
    int lat;
    in_valid = 1'b1; in_data = 32'h4000_0000; in_bank = 0;
    tick();
    in_data = 32'h4040_0000;
    wait_out(1, lat);
    total++; if (lat !== 2 + 2 * ML) begin bad++; $display("FAIL bp_latency got=%0d exp=%0d", lat, 2 + 2 * ML); end
    for (int i = 0; i < 5; i++) begin
      total++; if (out_data !== 32'h40A0_0000) begin bad++; $display("FAIL bp_hold_data cyc=%0d got=%h exp=40a00000", i, out_data); end
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold_flags cyc=%0d got valid=%b ready=%b exp valid=1 ready=0", i, out_valid, in_ready);
      end
      tick();
    end
    pop_out();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_next_accept_busy got=%b exp=1", busy); end
    wait_out(1, lat);
    total++; if (out_data !== 32'h4108_0000) begin bad++; $display("FAIL bp_next_result got=%h exp=41080000", out_data); end
    total++; if (lat !== 2 + 2 * ML)        begin bad++; $display("FAIL bp_next_latency got=%0d exp=%0d", lat, 2 + 2 * ML); end
    pop_out();
  endtask

  task automatic test_coef_write();
    logic [DW-1:0] res;
    int            lat;
    in_valid = 1'b1; in_data = 32'h4000_0000; in_bank = 0;
    tick();
    in_valid = 1'b0;
    tick();
    coef_we = 1'b1; len_we = 1'b1; coef_bank = 0; coef_addr = 0; coef_wdata = 32'h4040_0000; len_wdata = 0;
    tick();
    coef_we = 1'b0; len_we = 1'b0;
    total++; if (coef_err !== 1'b1) begin bad++; $display("FAIL wr_conflict_err got=%b exp=1", coef_err); end
    tick();
    total++; if (coef_err !== 1'b0) begin bad++; $display("FAIL wr_conflict_pulse_end got=%b exp=0", coef_err); end
    coef_we = 1'b1; coef_bank = 2; coef_addr = 0; coef_wdata = 32'h4040_0000;
    tick();
    coef_we = 1'b0;
    total++; if (coef_err !== 1'b0) begin bad++; $display("FAIL wr_other_bank_err got=%b exp=0", coef_err); end
    wait_out(5, lat);
    total++; if (out_data !== 32'h40A0_0000) begin bad++; $display("FAIL wr_conflict_result got=%h exp=40a00000", out_data); end
    total++; if (lat !== 2 + 2 * ML)        begin bad++; $display("FAIL wr_conflict_latency got=%0d exp=%0d", lat, 2 + 2 * ML); end
    pop_out();
    eval(32'h4000_0000, 2, res, lat);
    total++; if (res !== 32'h4040_0000) begin bad++; $display("FAIL wr_bank2_readback got=%h exp=40400000", res); end
  endtask

  task automatic test_dual_write();
    logic [DW-1:0] res;
    int            lat;
    coef_we = 1'b1; len_we = 1'b1; coef_bank = 3; coef_addr = 1; coef_wdata = FP32_ONE; len_wdata = 1;
    tick();
    coef_we = 1'b0; len_we = 1'b0;
    wr_coef(3, 0, FP32_ONE);
    eval(32'h4000_0000, 3, res, lat);
    total++; if (res !== 32'h4040_0000) begin bad++; $display("FAIL dual_write_result got=%h exp=40400000", res); end
    total++; if (lat !== 2 + ML)        begin bad++; $display("FAIL dual_write_latency got=%0d exp=%0d", lat, 2 + ML); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] res;
    int            lat;
    in_valid = 1'b1; in_data = 32'h4000_0000; in_bank = 0;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rstn_i = 1'b0;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
    total++; if (out_data !== 32'd0) begin bad++; $display("FAIL rst_mid_out_data got=%h exp=0", out_data); end
    tick();
    rstn_i = 1'b1;
    repeat (2 * ML) tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_stale_mac got=%b exp=0", out_valid); end
    eval(32'h4000_0000, 0, res, lat);
    total++; if (res !== FP32_ONE) begin bad++; $display("FAIL rst_mid_len0_result got=%h exp=%h", res, FP32_ONE); end
    total++; if (lat !== 2)        begin bad++; $display("FAIL rst_mid_len0_latency got=%0d exp=2", lat); end
  endtask

  initial begin
    test_reset();
    test_eval_bank0();
    test_len_zero();
    test_nan();
    test_back_to_back();
    test_coef_write();
    test_dual_write();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
